sprite_cmd_encoder: RTL and testbench



---
 rtl/sprite_cmd_pkg.sv | 77 +++++++
 rtl/sprite_desc_fifo.sv | 50 +++++
 rtl/sprite_cmd_encoder.sv | 131 +++++++++++++
 tb/tb_sprite_cmd_encoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command encoder: action/type codes,
// command word bit positions, the packed sprite descriptor, FSM states
// and the word-building helpers.
package sprite_cmd_pkg;

  localparam logic [3:0] ACT_UPDATE = 4'b0001;
  localparam logic [3:0] ACT_SWAP   = 4'b1111;

  localparam logic [2:0] T_VISPAT = 3'b001;
  localparam logic [2:0] T_X      = 3'b010;
  localparam logic [2:0] T_Y      = 3'b011;
  localparam logic [2:0] T_ATTR   = 3'b100;

  // Command word layout: [31:26] component, [25:21] zero, [20:17] action,
  // [16:14] action type, [13] buffer toggle, [12:0] action data.
  localparam int CMP_LSB = 26;
  localparam int ACT_LSB = 17;
  localparam int TYP_LSB = 14;
  localparam int TOG_BIT = 13;

  typedef struct packed {
    logic [5:0] component;
    logic       visible;
    logic       flip;
    logic [4:0] pattern;
    logic [9:0] x;
    logic [9:0] y;
    logic [9:0] attr;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VISPAT,
    S_XPOS,
    S_YPOS,
    S_ATTR,
    S_SWAP
  } state_t;

  // Build one per-field update word for descriptor d.
  function automatic logic [31:0] update_word(input desc_t d, input logic [2:0] typ,
                                              input logic tog);
    logic [12:0] data;
    logic [31:0] w;
    data = '0;
    case (typ)
      T_VISPAT: begin
        data[12]  = d.visible;
        data[11]  = d.flip;
        data[4:0] = d.pattern;
      end
      T_X:     data[9:0] = d.x;
      T_Y:     data[9:0] = d.y;
      T_ATTR:  data[9:0] = d.attr;
      default: data = '0;
    endcase
    w = '0;
    w[CMP_LSB +: 6] = d.component;
    w[ACT_LSB +: 4] = ACT_UPDATE;
    w[TYP_LSB +: 3] = typ;
    w[TOG_BIT]      = tog;
    w[12:0]         = data;
    return w;
  endfunction

  // Buffer-swap word: component, type and data are all zero.
  function automatic logic [31:0] swap_word(input logic tog);
    logic [31:0] w;
    w = '0;
    w[ACT_LSB +: 4] = ACT_SWAP;
    w[TOG_BIT]      = tog;
    return w;
  endfunction

endpackage

// File: rtl/sprite_desc_fifo.sv
// Synchronous descriptor FIFO with full/empty flags; reset flushes it.
// Caller guarantees no push when full and no pop when empty.
module sprite_desc_fifo #(
  parameter int WIDTH = 43,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;

  // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/sprite_cmd_encoder.sv
// Sprite command encoder: buffers sprite descriptors, serialises each into
// its per-field update words for the back buffer, and emits the buffer-swap
// word once a requested frame has fully drained.
// Optional feature macro: SPRITE_CMD_ATTR_EN (adds the attribute word,
// 4 words per sprite instead of 3).
module sprite_cmd_encoder
  import sprite_cmd_pkg::*;
#(
  parameter int   FIFO_DEPTH = 4,
  parameter logic RESET_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_component,
  input  logic        in_visible,
  input  logic        in_flip,
  input  logic [4:0]  in_pattern,
  input  logic [9:0]  in_x,
  input  logic [9:0]  in_y,
  input  logic [9:0]  in_attr,
  input  logic        frame_done,
  output logic [31:0] writedata,
  output logic        write,
  input  logic        cmd_ready,
  output logic        back_buffer,
  output logic        busy
);

  desc_t  in_desc;
  desc_t  head;
  desc_t  hold_p0;
  state_t state;
  logic   swap_pending;
  logic   full;
  logic   empty;
  logic   push;
  logic   pop;

  assign in_desc = '{component: in_component, visible: in_visible, flip: in_flip,
                     pattern: in_pattern, x: in_x, y: in_y, attr: in_attr};

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == S_IDLE) && !empty;
  assign busy     = (state != S_IDLE) || !empty || swap_pending;

  sprite_desc_fifo #(
    .WIDTH (DESC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_desc),
    .pop     (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty)
  );

  // Hold register: the descriptor currently being serialised (data, no reset).
  always_ff @(posedge clk) begin
    if (pop) hold_p0 <= head;
  end

  // Word sequencer: registered write/writedata, swap tracking and back buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      write        <= 1'b0;
      writedata    <= '0;
      back_buffer  <= RESET_BACK;
      swap_pending <= 1'b0;
    end else begin
      swap_pending <= swap_pending | frame_done;
      case (state)
        S_IDLE: begin
          // Queued sprites always drain before a pending swap.
          if (!empty) begin
            state     <= S_VISPAT;
            write     <= 1'b1;
            writedata <= update_word(head, T_VISPAT, back_buffer);
          end else if (swap_pending) begin
            state     <= S_SWAP;
            write     <= 1'b1;
            writedata <= swap_word(back_buffer);
          end
        end
        S_VISPAT: if (cmd_ready) begin
          state     <= S_XPOS;
          writedata <= update_word(hold_p0, T_X, back_buffer);
        end
        S_XPOS: if (cmd_ready) begin
          state     <= S_YPOS;
          writedata <= update_word(hold_p0, T_Y, back_buffer);
        end
        S_YPOS: if (cmd_ready) begin
`ifdef SPRITE_CMD_ATTR_EN
          state     <= S_ATTR;
          writedata <= update_word(hold_p0, T_ATTR, back_buffer);
`else
          state     <= S_IDLE;
          write     <= 1'b0;
          writedata <= '0;
`endif
        end
        S_ATTR: if (cmd_ready) begin
          state     <= S_IDLE;
          write     <= 1'b0;
          writedata <= '0;
        end
        S_SWAP: if (cmd_ready) begin
          // A frame_done arriving in the accept cycle re-arms the next swap.
          state        <= S_IDLE;
          write        <= 1'b0;
          writedata    <= '0;
          back_buffer  <= ~back_buffer;
          swap_pending <= frame_done;
        end
        default: begin
          state     <= S_IDLE;
          write     <= 1'b0;
          writedata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_cmd_encoder.sv
// Self-checking bench for sprite_cmd_encoder with a word scoreboard.
// Honours SPRITE_CMD_ATTR_EN for the number of words per sprite.
module tb_sprite_cmd_encoder;

`ifdef SPRITE_CMD_ATTR_EN
  localparam int WPS = 4;
`else
  localparam int WPS = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_component = '0;
  logic        in_visible = 1'b0;
  logic        in_flip = 1'b0;
  logic [4:0]  in_pattern = '0;
  logic [9:0]  in_x = '0;
  logic [9:0]  in_y = '0;
  logic [9:0]  in_attr = '0;
  logic        frame_done = 1'b0;
  logic [31:0] writedata;
  logic        write;
  logic        cmd_ready = 1'b1;
  logic        back_buffer;
  logic        busy;

  always #5 clk = ~clk;

  sprite_cmd_encoder #(.FIFO_DEPTH(4), .RESET_BACK(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_component (in_component),
    .in_visible   (in_visible),
    .in_flip      (in_flip),
    .in_pattern   (in_pattern),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_attr      (in_attr),
    .frame_done   (frame_done),
    .writedata    (writedata),
    .write        (write),
    .cmd_ready    (cmd_ready),
    .back_buffer  (back_buffer),
    .busy         (busy)
  );

  int          checks = 0;
  int          failures = 0;
  int          words = 0;
  logic [31:0] sb[$];
  logic        m_bb = 1'b1;
  logic        m_pend = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] m_upd(input logic [5:0] comp, input int typ,
                                        input logic tog, input logic [12:0] data);
    return (32'(comp) << 26) | (32'h1 << 17) | (32'(typ) << 14) | (32'(tog) << 13) | 32'(data);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one descriptor and queue its expected words once it will be accepted.
  task automatic push_desc(input logic [5:0] comp, input logic vis, input logic flp,
                           input logic [4:0] pat, input logic [9:0] x,
                           input logic [9:0] y, input logic [9:0] attr);
    int n;
    in_valid = 1'b1;
    in_component = comp; in_visible = vis; in_flip = flp; in_pattern = pat;
    in_x = x; in_y = y; in_attr = attr;
    n = 0;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    if (!in_ready) chk("push_timeout", {31'b0, in_ready}, 32'd1);
    else begin
      sb.push_back(m_upd(comp, 1, m_bb, {vis, flp, 6'b0, pat}));
      sb.push_back(m_upd(comp, 2, m_bb, {3'b0, x}));
      sb.push_back(m_upd(comp, 3, m_bb, {3'b0, y}));
      if (WPS == 4) sb.push_back(m_upd(comp, 4, m_bb, {3'b0, attr}));
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_done = 1'b1;
    if (!m_pend) begin
      sb.push_back((32'hF << 17) | (32'(m_bb) << 13));
      m_bb = ~m_bb;
      m_pend = 1'b1;
    end
    tick();
    frame_done = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic wait_write();
    int n;
    n = 0;
    while (!write && n < 50) begin
      tick();
      n++;
    end
    chk("wait_write", {31'b0, write}, 32'd1);
  endtask

  // Scoreboard monitor: compares accepted words, and checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_write", {31'b0, write}, 32'd1);
        chk("stall_data", writedata, prev_word);
      end
      if (write && cmd_ready) begin
        logic [31:0] exp;
        words++;
        if (sb.size() == 0) chk("spurious_word", writedata, 32'h0);
        else begin
          exp = sb.pop_front();
          chk("word", writedata, exp);
          if (exp[20:17] == 4'hF) m_pend = 1'b0;
        end
      end
      prev_stall = write && !cmd_ready;
      prev_word  = writedata;
    end
  end

  initial begin
    int w0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_write", {31'b0, write}, 32'd0);
    chk("rst_data", writedata, 32'd0);
    chk("rst_bb", {31'b0, back_buffer}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);

    // 1: single sprite, latency and word sequence
    w0 = words;
    cmd_ready = 1'b1;
    push_desc(6'd8, 1'b1, 1'b0, 5'd0, 10'd100, 10'd200, 10'd5);
    chk("lat_n1", {31'b0, write}, 32'd0);
    tick();
    chk("lat_n2", {31'b0, write}, 32'd1);
    drain();
    chk("t1_count", 32'(words - w0), 32'(WPS));

    // 2: swap with empty FIFO
    pulse_frame();
    drain();
    chk("t2_bb", {31'b0, back_buffer}, 32'd0);

    // 3: fill FIFO while sink stalled, then release
    w0 = words;
    cmd_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_desc(6'(i + 1), 1'(i), 1'(i >> 1), 5'(3 * i + 1), 10'(17 * i + 3),
                10'(29 * i + 7), 10'(41 * i + 11));
    chk("t3_ready4", {31'b0, in_ready}, 32'd1);
    push_desc(6'd63, 1'b1, 1'b1, 5'd31, 10'h3FF, 10'h2AA, 10'h155);
    chk("t3_full", {31'b0, in_ready}, 32'd0);
    cmd_ready = 1'b1;
    drain();
    chk("t3_count", 32'(words - w0), 32'(5 * WPS));

    // 4: frame_done (twice) during XPOS with more sprites queued
    w0 = words;
    cmd_ready = 1'b0;
    push_desc(6'd10, 1'b0, 1'b1, 5'd9, 10'd1, 10'd2, 10'd3);
    push_desc(6'd11, 1'b1, 1'b1, 5'd10, 10'd4, 10'd5, 10'd6);
    push_desc(6'd12, 1'b0, 1'b0, 5'd11, 10'd7, 10'd8, 10'd9);
    wait_write();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    pulse_frame();
    tick();
    pulse_frame();
    cmd_ready = 1'b1;
    drain();
    chk("t4_count", 32'(words - w0), 32'(3 * WPS + 1));
    chk("t4_bb", {31'b0, back_buffer}, 32'd1);

    // 5: random stalls across one sprite
    w0 = words;
    cmd_ready = 1'b0;
    push_desc(6'd33, 1'b1, 1'b0, 5'd21, 10'd512, 10'd300, 10'd777);
    for (int n = 0; n < 400 && (sb.size() != 0 || busy); n++) begin
      cmd_ready = 1'($urandom_range(0, 1));
      tick();
    end
    cmd_ready = 1'b1;
    drain();
    chk("t5_count", 32'(words - w0), 32'(WPS));

    // move back buffer to 0 so the reset value is observable
    pulse_frame();
    drain();

    // 6: reset while in YPOS
    cmd_ready = 1'b0;
    push_desc(6'd5, 1'b1, 1'b1, 5'd2, 10'd40, 10'd50, 10'd60);
    wait_write();
    cmd_ready = 1'b1;
    tick();
    tick();
    cmd_ready = 1'b0;
    if (sb.size() != 0) chk("t6_ypos", writedata, sb[0]);
    else chk("t6_ypos_queue", 32'(sb.size()), 32'd1);
    reset = 1'b1;
    sb.delete();
    m_bb = 1'b1;
    m_pend = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_write", {31'b0, write}, 32'd0);
    chk("t6_busy", {31'b0, busy}, 32'd0);
    chk("t6_bb", {31'b0, back_buffer}, 32'd1);
    w0 = words;
    cmd_ready = 1'b1;
    repeat (20) tick();
    chk("t6_quiet", 32'(words - w0), 32'd0);
    chk("t6_idle", {31'b0, write}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
